// File: rtl/alu_ctrl_issue.sv
// rtl/alu_ctrl_issue.sv - MIPS ALU control decoder feeding a 2-entry issue FIFO.
// Instructions are decoded on entry; the head entry drives the ALU control outputs.
module alu_ctrl_issue (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] instr,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [5:0]  alu_fun,
  output logic        sign,
  output logic        src_a_shamt,
  output logic        src_b_imm,
  output logic [31:0] imm_ext,
  output logic        illegal,
  output logic [7:0]  illegal_cnt
);

  typedef struct packed {
    logic [5:0]  alu_fun;
    logic        sign;
    logic        src_a_shamt;
    logic        src_b_imm;
    logic [31:0] imm_ext;
    logic        illegal;
  } entry_t;

  entry_t      dec;
  entry_t      slot0_q, slot0_d;
  entry_t      slot1_q, slot1_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [7:0]  illegal_cnt_q, illegal_cnt_d;
  logic        push, pop;

  logic [5:0]  opcode, funct;
  logic [4:0]  rt;
  logic [15:0] imm;

  assign opcode = instr[31:26];
  assign rt     = instr[20:16];
  assign funct  = instr[5:0];
  assign imm    = instr[15:0];

  always_comb begin
    dec         = '0;
    dec.imm_ext = {{16{imm[15]}}, imm};
    case (opcode)
      6'h00: begin
        case (funct)
          6'h20: begin dec.alu_fun = 6'b000000; dec.sign = 1'b1; end
          6'h21: dec.alu_fun = 6'b000000;
          6'h22: begin dec.alu_fun = 6'b000001; dec.sign = 1'b1; end
          6'h23: dec.alu_fun = 6'b000001;
          6'h24: dec.alu_fun = 6'b011000;
          6'h25: dec.alu_fun = 6'b011110;
          6'h26: dec.alu_fun = 6'b010110;
          6'h27: dec.alu_fun = 6'b010001;
          6'h2A: begin dec.alu_fun = 6'b110101; dec.sign = 1'b1; end
          6'h2B: dec.alu_fun = 6'b110101;
          6'h00: begin dec.alu_fun = 6'b100000; dec.src_a_shamt = 1'b1; end
          6'h02: begin dec.alu_fun = 6'b100001; dec.src_a_shamt = 1'b1; end
          6'h03: begin dec.alu_fun = 6'b100011; dec.src_a_shamt = 1'b1; end
          6'h08: dec.alu_fun = 6'b011010;
          default: dec.illegal = 1'b1;
        endcase
      end
      6'h08: begin dec.alu_fun = 6'b000000; dec.sign = 1'b1; dec.src_b_imm = 1'b1; end
      6'h09: begin dec.alu_fun = 6'b000000; dec.src_b_imm = 1'b1; end
      6'h0A: begin dec.alu_fun = 6'b110101; dec.sign = 1'b1; dec.src_b_imm = 1'b1; end
      6'h0B: begin dec.alu_fun = 6'b110101; dec.src_b_imm = 1'b1; end
      6'h0C: begin dec.alu_fun = 6'b011000; dec.src_b_imm = 1'b1; dec.imm_ext = {16'h0, imm}; end
      6'h0D: begin dec.alu_fun = 6'b011110; dec.src_b_imm = 1'b1; dec.imm_ext = {16'h0, imm}; end
      6'h0F: begin dec.alu_fun = 6'b011110; dec.src_b_imm = 1'b1; dec.imm_ext = {imm, 16'h0}; end
      6'h23: begin dec.alu_fun = 6'b000000; dec.sign = 1'b1; dec.src_b_imm = 1'b1; end
      6'h2B: begin dec.alu_fun = 6'b000000; dec.sign = 1'b1; dec.src_b_imm = 1'b1; end
      6'h04: begin dec.alu_fun = 6'b110011; dec.sign = 1'b1; end
      6'h05: begin dec.alu_fun = 6'b110001; dec.sign = 1'b1; end
      6'h06: begin dec.alu_fun = 6'b111101; dec.sign = 1'b1; end
      6'h07: begin dec.alu_fun = 6'b111111; dec.sign = 1'b1; end
      6'h01: begin
        // Only bltz (rt=0) is supported in the REGIMM group.
        if (rt == 5'd0) begin
          dec.alu_fun = 6'b111011;
          dec.sign    = 1'b1;
        end else begin
          dec.illegal = 1'b1;
        end
      end
      default: dec.illegal = 1'b1;
    endcase
  end

  assign in_ready  = !reset && (cnt_q != 2'd2);
  assign out_valid = (cnt_q != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_comb begin
    cnt_d         = cnt_q;
    slot0_d       = slot0_q;
    slot1_d       = slot1_q;
    illegal_cnt_d = illegal_cnt_q;
    if (flush) begin
      cnt_d = 2'd0;
    end else begin
      if (push && dec.illegal && illegal_cnt_q != 8'hFF) begin
        illegal_cnt_d = illegal_cnt_q + 8'd1;
      end
      // Push with pop only happens at one entry held, so the new entry becomes head.
      if (push && pop) begin
        slot0_d = dec;
      end else if (pop) begin
        slot0_d = slot1_q;
        cnt_d   = cnt_q - 2'd1;
      end else if (push) begin
        if (cnt_q == 2'd0) slot0_d = dec;
        else               slot1_d = dec;
        cnt_d = cnt_q + 2'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q         <= 2'd0;
      slot0_q       <= '0;
      slot1_q       <= '0;
      illegal_cnt_q <= 8'd0;
    end else begin
      cnt_q         <= cnt_d;
      slot0_q       <= slot0_d;
      slot1_q       <= slot1_d;
      illegal_cnt_q <= illegal_cnt_d;
    end
  end

  assign alu_fun     = slot0_q.alu_fun;
  assign sign        = slot0_q.sign;
  assign src_a_shamt = slot0_q.src_a_shamt;
  assign src_b_imm   = slot0_q.src_b_imm;
  assign imm_ext     = slot0_q.imm_ext;
  assign illegal     = slot0_q.illegal;
  assign illegal_cnt = illegal_cnt_q;

endmodule

// File: tb/tb_alu_ctrl_issue.sv
// tb/tb_alu_ctrl_issue.sv - directed self-checking bench for alu_ctrl_issue.
module tb_alu_ctrl_issue;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic        out_valid;
  logic        out_ready;
  logic [5:0]  alu_fun;
  logic        sign;
  logic        src_a_shamt;
  logic        src_b_imm;
  logic [31:0] imm_ext;
  logic        illegal;
  logic [7:0]  illegal_cnt;

  int total  = 0;
  int passed = 0;

  alu_ctrl_issue dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
    .out_valid(out_valid), .out_ready(out_ready),
    .alu_fun(alu_fun), .sign(sign), .src_a_shamt(src_a_shamt), .src_b_imm(src_b_imm),
    .imm_ext(imm_ext), .illegal(illegal), .illegal_cnt(illegal_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic push(input logic [31:0] w);
    @(negedge clk);
    in_valid = 1'b1;
    instr    = w;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic pop_one();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; instr = 32'h0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", {31'b0, in_ready}, 32'd0);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_alu_fun", {26'b0, alu_fun}, 32'd0);
    check("rst_imm_ext", imm_ext, 32'd0);
    check("rst_illegal_cnt", {24'b0, illegal_cnt}, 32'd0);
    @(negedge clk) reset = 1'b0;
    #1 check("post_rst_in_ready", {31'b0, in_ready}, 32'd1);

    // add with out_ready=1: appears one edge later, then drains
    @(negedge clk);
    out_ready = 1'b1; in_valid = 1'b1; instr = 32'h00851020;
    @(posedge clk);
    #1 in_valid = 1'b0;
    check("add_out_valid", {31'b0, out_valid}, 32'd1);
    check("add_alu_fun", {26'b0, alu_fun}, 32'h00);
    check("add_sign", {31'b0, sign}, 32'd1);
    check("add_src_b_imm", {31'b0, src_b_imm}, 32'd0);
    @(posedge clk);
    #1 out_ready = 1'b0;
    check("add_drained", {31'b0, out_valid}, 32'd0);

    // addiu then andi held, then pop
    push(32'h2408FFFF);
    push(32'h3108FFFF);
    check("full_in_ready", {31'b0, in_ready}, 32'd0);
    check("addiu_imm_ext", imm_ext, 32'hFFFFFFFF);
    check("addiu_sign", {31'b0, sign}, 32'd0);
    check("addiu_src_b_imm", {31'b0, src_b_imm}, 32'd1);
    @(posedge clk);
    #1 check("hold_imm_ext", imm_ext, 32'hFFFFFFFF);
    pop_one();
    check("andi_imm_ext", imm_ext, 32'h0000FFFF);
    check("andi_alu_fun", {26'b0, alu_fun}, 32'b011000);
    check("after_pop_in_ready", {31'b0, in_ready}, 32'd1);
    pop_one();
    check("empty_again", {31'b0, out_valid}, 32'd0);

    // sra
    push(32'h00021883);
    check("sra_alu_fun", {26'b0, alu_fun}, 32'b100011);
    check("sra_shamt", {31'b0, src_a_shamt}, 32'd1);
    pop_one();

    // beq held, then simultaneous push lui / pop
    push(32'h10000000);
    check("beq_alu_fun", {26'b0, alu_fun}, 32'b110011);
    check("beq_sign", {31'b0, sign}, 32'd1);
    check("beq_src_b_imm", {31'b0, src_b_imm}, 32'd0);
    @(negedge clk);
    in_valid = 1'b1; instr = 32'h3C081234; out_ready = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0; out_ready = 1'b0;
    check("pp_out_valid", {31'b0, out_valid}, 32'd1);
    check("pp_in_ready", {31'b0, in_ready}, 32'd1);
    check("lui_alu_fun", {26'b0, alu_fun}, 32'b011110);
    check("lui_imm_ext", imm_ext, 32'h12340000);
    pop_one();
    check("pp_one_entry", {31'b0, out_valid}, 32'd0);

    // opcode 01 with rt!=0 is illegal
    push(32'h04010000);
    check("regimm_illegal", {31'b0, illegal}, 32'd1);
    check("regimm_cnt", {24'b0, illegal_cnt}, 32'd1);
    pop_one();

    // 300 illegal pushes saturate the counter
    @(negedge clk);
    in_valid = 1'b1; instr = 32'hFC000000; out_ready = 1'b1;
    repeat (300) @(posedge clk);
    #1 in_valid = 1'b0;
    check("ill_illegal", {31'b0, illegal}, 32'd1);
    check("ill_alu_fun", {26'b0, alu_fun}, 32'd0);
    check("ill_src_b_imm", {31'b0, src_b_imm}, 32'd0);
    check("ill_cnt_sat", {24'b0, illegal_cnt}, 32'd255);
    @(posedge clk);
    #1 out_ready = 1'b0;
    check("ill_drained", {31'b0, out_valid}, 32'd0);

    // flush with 2 held overrides pop
    push(32'h00851020);
    push(32'h00851020);
    check("pre_flush_full", {31'b0, in_ready}, 32'd0);
    @(negedge clk);
    flush = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0; out_ready = 1'b0;
    check("flush_out_valid", {31'b0, out_valid}, 32'd0);
    check("flush_in_ready", {31'b0, in_ready}, 32'd1);
    check("flush_cnt_kept", {24'b0, illegal_cnt}, 32'd255);

    // asynchronous reset between edges
    push(32'h00851020);
    check("pre_areset_valid", {31'b0, out_valid}, 32'd1);
    #2 reset = 1'b1;
    #1;
    check("areset_out_valid", {31'b0, out_valid}, 32'd0);
    check("areset_in_ready", {31'b0, in_ready}, 32'd0);
    check("areset_cnt", {24'b0, illegal_cnt}, 32'd0);
    @(negedge clk) reset = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
